// File: rtl/gpr_pkg.sv
// Shared constants and helpers for the multi-port general-purpose register file.
package gpr_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int NREG_DEFAULT = 32;
  localparam int unsigned REG_ZERO = 0;

  // Register index width; a single-entry file still needs one address bit.
  function automatic int gpr_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  typedef logic [$clog2(NREG_DEFAULT)-1:0] reg_idx_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy tracking: alloc sets, write-back clears, flush clears all.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = gpr_aw(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_rd,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    busy_raw
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Alloc is applied after the clears so a same-cycle alloc wins over an
  // older producer's write-back; flush then drops everything, alloc included.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) busy_d[wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (alloc_en) busy_d[alloc_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    busy_raw = '0;
    for (int i = 0; i < NRD; i++) begin
      busy_raw[i] = busy_q[rd_addr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/gpr_mp.sv
// Multi-port register file with same-cycle write bypass and busy scoreboard.
module gpr_mp
  import gpr_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREG   = NREG_DEFAULT,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = gpr_aw(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_rd,
  input  logic                flush
);

  logic [XLEN-1:0] regs [NREG];
  logic [NRD-1:0]  busy_raw;

  gpr_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .alloc_en (alloc_en),
    .alloc_rd (alloc_rd),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .busy_raw (busy_raw)
  );

  // Later ports are visited last, so the highest-numbered writer wins.
  // regs[0] is only ever loaded by reset and therefore stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(REG_ZERO))) begin
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Bypass is gated by rst_n so reads are zero throughout reset even while
  // a write is still being presented.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i*AW +: AW] != AW'(REG_ZERO)) begin
        rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
        rd_busy[i]              = busy_raw[i];
        if ((BYPASS != 0) && rst_n) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
              rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
              rd_busy[i]              = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gpr_mp.sv
// Randomised and directed check of gpr_mp against a behavioural register model.
module tb_gpr_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic [2*AW-1:0] rd_addr  = '0;
  logic [1:0]      wr_en    = '0;
  logic [2*AW-1:0] wr_addr  = '0;
  logic [127:0]    wr_data  = '0;
  logic            alloc_en = 1'b0;
  logic [AW-1:0]   alloc_rd = '0;
  logic            flush    = 1'b0;

  logic [127:0] rd_data_b1, rd_data_b0;
  logic [1:0]   rd_busy_b1, rd_busy_b0;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0]     mregs [NREG] = '{default: '0};
  logic [NREG-1:0] mbusy = '0;

  logic [127:0] e_d1, e_d0;
  logic [1:0]   e_b1, e_b0;
  logic [63:0]  e_d;
  logic         e_b;

  always #5 clk = ~clk;

  gpr_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b1),
    .rd_busy(rd_busy_b1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .flush(flush)
  );

  gpr_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b0),
    .rd_busy(rd_busy_b0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .flush(flush)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural state advances on each edge; reset wipes it at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) mregs[r] = '0;
      mbusy = '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
          mregs[wr_addr[j*AW +: AW]] = wr_data[j*64 +: 64];
          mbusy[wr_addr[j*AW +: AW]] = 1'b0;
        end
      end
      if (alloc_en && alloc_rd != 0) mbusy[alloc_rd] = 1'b1;
      if (flush) mbusy = '0;
    end
  end

  // Expected read for one port: newest matching writer (highest port) first.
  function automatic void expect_port(input int i, input bit byp,
                                      output logic [63:0] d, output logic b);
    int a;
    a = int'(rd_addr[i*AW +: AW]);
    d = '0;
    b = 1'b0;
    if (rst_n && a != 0) begin
      d = mregs[a];
      b = mbusy[a];
      if (byp) begin
        for (int j = 1; j >= 0; j--) begin
          if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
            d = wr_data[j*64 +: 64];
            b = 1'b0;
            break;
          end
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      expect_port(i, 1'b1, e_d, e_b);
      e_d1[i*64 +: 64] = e_d;
      e_b1[i]          = e_b;
      expect_port(i, 1'b0, e_d, e_b);
      e_d0[i*64 +: 64] = e_d;
      e_b0[i]          = e_b;
    end
    chk("model_rd_data_byp1", rd_data_b1, e_d1);
    chk("model_rd_busy_byp1", {126'b0, rd_busy_b1}, {126'b0, e_b1});
    chk("model_rd_data_byp0", rd_data_b0, e_d0);
    chk("model_rd_busy_byp0", {126'b0, rd_busy_b0}, {126'b0, e_b0});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    alloc_en = 1'b0;
    alloc_rd = '0;
    flush    = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [63:0] d);
    wr_en[p]             = 1'b1;
    wr_addr[p*AW +: AW]  = a;
    wr_data[p*64 +: 64]  = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < NREG; k += 2) begin
      cyc();
      rd(0, AW'(k));
      rd(1, AW'(k + 1));
      #2;
      chk("reset_rd_data", rd_data_b1, '0);
      chk("reset_rd_busy", {126'b0, rd_busy_b1}, '0);
    end

    cyc(); idle(); wr(0, 5'd5, 64'hDEAD_BEEF_0000_0001);
    cyc(); idle(); rd(0, 5'd5); #2;
    chk("x5_readback", {64'b0, rd_data_b0[63:0]}, 64'hDEAD_BEEF_0000_0001);

    cyc(); idle(); wr(0, 5'd7, 64'h1234); rd(0, 5'd7); #2;
    chk("bypass_same_cycle", {64'b0, rd_data_b1[63:0]}, 64'h1234);
    chk("nobypass_old", {64'b0, rd_data_b0[63:0]}, 64'h0);
    cyc(); idle(); #2;
    chk("nobypass_next", {64'b0, rd_data_b0[63:0]}, 64'h1234);

    cyc(); idle(); wr(0, 5'd9, 64'hAAAA); wr(1, 5'd9, 64'hBBBB); rd(0, 5'd9); #2;
    chk("conflict_bypass", {64'b0, rd_data_b1[63:0]}, 64'hBBBB);
    cyc(); idle(); #2;
    chk("conflict_stored", {64'b0, rd_data_b0[63:0]}, 64'hBBBB);

    cyc(); idle(); alloc_en = 1'b1; alloc_rd = 5'd3; rd(0, 5'd3); #2;
    chk("alloc_not_yet", {127'b0, rd_busy_b1[0]}, 1'b0);
    cyc(); idle(); #2;
    chk("alloc_busy", {127'b0, rd_busy_b1[0]}, 1'b1);
    cyc(); idle(); wr(0, 5'd3, 64'h55); #2;
    chk("busy_masked", {127'b0, rd_busy_b1[0]}, 1'b0);
    chk("busy_unmasked_b0", {127'b0, rd_busy_b0[0]}, 1'b1);
    cyc(); idle(); #2;
    chk("busy_cleared", {126'b0, rd_busy_b1[0], rd_busy_b0[0]}, 2'b00);
    cyc(); idle(); alloc_en = 1'b1; alloc_rd = 5'd3; wr(0, 5'd3, 64'h55);
    cyc(); idle(); #2;
    chk("alloc_beats_write", {127'b0, rd_busy_b1[0]}, 1'b1);
    chk("alloc_write_data", {64'b0, rd_data_b0[63:0]}, 64'h55);

    cyc(); idle(); alloc_en = 1'b1; alloc_rd = 5'd4;
    cyc(); idle(); alloc_en = 1'b1; alloc_rd = 5'd6;
    cyc(); idle(); alloc_en = 1'b1; alloc_rd = 5'd8;
    cyc(); idle(); rd(0, 5'd4); rd(1, 5'd6); #2;
    chk("pre_flush_busy", {126'b0, rd_busy_b0}, 2'b11);
    flush = 1'b1; alloc_en = 1'b1; alloc_rd = 5'd10;
    cyc(); idle(); rd(0, 5'd8); rd(1, 5'd10); #2;
    chk("flush_8_10", {126'b0, rd_busy_b0}, 2'b00);
    rd(0, 5'd4); rd(1, 5'd3); #1;
    chk("flush_4_3", {126'b0, rd_busy_b0}, 2'b00);

    cyc(); idle(); wr(0, 5'd0, 64'hFFFF); alloc_en = 1'b1; alloc_rd = 5'd0;
    rd(0, 5'd0); rd(1, 5'd0); #2;
    chk("x0_bypass", rd_data_b1, '0);
    cyc(); idle(); #2;
    chk("x0_after", {rd_data_b1[63:0], 62'b0, rd_busy_b1}, '0);

    cyc(); idle(); wr(1, 5'd12, 64'h777); rd(0, 5'd12); #1;
    chk("x12_bypass_pre_reset", {64'b0, rd_data_b1[63:0]}, 64'h777);
    #1 rst_n = 1'b0;
    #1;
    chk("x12_in_reset", {rd_data_b1[63:0], rd_data_b0[63:0]}, '0);
    cyc(); cyc();
    rst_n = 1'b1; idle(); #2;
    chk("x12_after_reset", {rd_data_b1[63:0], rd_data_b0[63:0]}, '0);

    repeat (3000) begin
      cyc();
      wr_en    = 2'($urandom_range(0, 3));
      wr_addr  = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      wr_data  = {$urandom, $urandom, $urandom, $urandom};
      rd_addr  = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      alloc_en = 1'($urandom_range(0, 1));
      alloc_rd = 5'($urandom_range(0, 15));
      flush    = ($urandom_range(0, 15) == 0);
    end

    cyc(); idle();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
- Parametrised multi-port general-purpose register file with write-to-read bypass and a per-register busy scoreboard.
- Sits between issue/EXU (read ports, busy query, destination allocation) and WB/LSU (write ports).
- Replaces the single-write, two-read register file for the dual-issue core.
- x0 is hardwired zero. All architectural registers are resettable.

Parameters:
- XLEN, 64, data width.
- NREG, 32, number of architectural registers including x0; must be a power of 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value only.
- AW, $clog2(NREG), localparam, register index width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  read indices; port i = bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data per port; combinational.
- rd_busy  out  NRD  per port: source has a pending producer; combinational.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write indices.
- wr_data  in  NWR*XLEN  write data.
- alloc_en  in  1  issue allocates destination alloc_rd; marks it busy.
- alloc_rd  in  AW  destination being allocated.
- flush  in  1  pipeline flush; clears every busy bit.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers x1..x(NREG-1) = 0.
  - all busy bits = 0.
  - consequently rd_data = 0 and rd_busy = 0 for every port while in reset.
  - Deassertion takes effect at the next posedge with no special sequencing.
- x0:
  - Writes are dropped.
  - Reads return 0 and rd_busy = 0 regardless of any write or bypass.
  - alloc_rd = 0 is ignored.
- Write ports:
  - Port j writes on posedge when wr_en[j] and wr_addr[j] != 0.
  - Multiple ports writing the same index in one cycle: the highest-numbered port wins.
- Reads:
  - Zero latency (combinational from rd_addr).
  - BYPASS=1: if any enabled write port matches rd_addr[i] (non-zero), rd_data[i] = that port's wr_data, using the same highest-index-wins priority; otherwise the stored value.
  - BYPASS=0: stored value only; new data is visible the cycle after the write.
- Scoreboard (busy[NREG-1:1]):
  - Set: alloc_en and alloc_rd != 0 → busy[alloc_rd] = 1 next cycle.
  - Clear: each enabled write with non-zero addr → busy[wr_addr] = 0 next cycle.
  - Alloc and write to the same index in one cycle: set wins (busy stays 1; the write belongs to an older producer). Data is still written.
  - flush: all busy = 0 next cycle. flush overrides alloc in the same cycle (alloc dropped); writes still update data.
  - rd_busy[i] = busy[rd_addr[i]], masked to 0 when BYPASS=1 and a same-cycle write matches rd_addr[i]. This mask applies even if busy is being re-set by alloc in the same cycle.
- Reset during a write or alloc: reset dominates; no state update occurs.
- No handshake back-pressure. Callers must not rely on busy to order two writes to the same index in the same cycle.

Decomposition:
- Package gpr_pkg:
  - XLEN default and AW derivation function.
  - Reg-index typedef.
  - Constant REG_ZERO = 0.
- Sub-module gpr_scoreboard:
  - Holds the busy vector.
  - Handles alloc/clear/flush priority.
  - Produces raw busy lookup per read port.
- gpr_mp instantiates gpr_scoreboard and applies the bypass mask on top.

Test Plan:
1. Reset then read all 32 indices on both ports → rd_data = 0 and rd_busy = 0 everywhere. Write x5 = 64'hDEAD_BEEF_0000_0001, read x5 next cycle → that value.
2. Same-cycle bypass: wr_en = 2'b01, wr_addr0 = 7, wr_data0 = 64'h1234, rd_addr0 = 7 → rd_data0 = 64'h1234 in that same cycle with BYPASS=1; with BYPASS=0 → old value (0), and 64'h1234 the following cycle.
3. Write conflict: both ports write x9, port0 = 64'hAAAA and port1 = 64'hBBBB → x9 = 64'hBBBB; bypass read in that cycle also returns 64'hBBBB.
4. Scoreboard:
   - alloc x3 → rd_busy = 1 on x3 next cycle.
   - Write x3 = 64'h55 → rd_busy masked 0 in the write cycle and stays 0 after.
   - Alloc x3 and write x3 in the same cycle → busy = 1 next cycle, data = 64'h55.
5. Flush: alloc x4, x6, x8 over three cycles, then flush together with alloc x10 → all busy 0 next cycle, including x10.
6. x0 and async reset:
   - Write x0 = 64'hFFFF and alloc x0 → read x0 gives 0, busy 0.
   - Assert rst_n low mid-cycle while wr_en is active on x12 → x12 reads 0 immediately and stays 0 after release.
